// File: rtl/rca_mult_ctrl.sv
// rtl/rca_mult_ctrl.sv - shift-and-add multiplier controller sharing one external ripple-carry adder
module rca_mult_ctrl #(
  parameter int WIDTH       = 32,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [2*WIDTH-1:0] add_sum,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // Only the low WIDTH+1 bits of the adder result carry information.
  logic unused_sum_hi;
  assign unused_sum_hi = ^add_sum[2*WIDTH-1:WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    add_a     = '0;
    add_b     = '0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          if (ZERO_BYPASS && ((op_a == '0) || (op_b == '0))) begin
            product_d = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        busy  = 1'b1;
        add_a = acc_q[2*WIDTH-1:WIDTH];
        add_b = mplier_q[0] ? mcand_q : '0;
        // Carry-out lands in the top bit; the retired low bit shifts out.
        acc_d    = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          product_d = acc_d;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_rca_mult_ctrl.sv
// tb/tb_rca_mult_ctrl.sv - self-checking bench for rca_mult_ctrl with and without zero bypass
module tb_rca_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [30:0] junk0, junk1;

  logic [31:0] add_a0, add_b0, add_a1, add_b1;
  logic [63:0] add_sum0, add_sum1, product0, product1;
  logic        busy0, done0, busy1, done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External ripple-carry adders; the upper result bits carry noise that must be ignored.
  assign add_sum0 = {junk0, {1'b0, add_a0} + {1'b0, add_b0}};
  assign add_sum1 = {junk1, {1'b0, add_a1} + {1'b0, add_b1}};

  rca_mult_ctrl #(.WIDTH(32), .ZERO_BYPASS(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .add_a(add_a0), .add_b(add_b0), .add_sum(add_sum0),
    .busy(busy0), .done(done0), .product(product0)
  );

  rca_mult_ctrl #(.WIDTH(32), .ZERO_BYPASS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1),
    .busy(busy1), .done(done1), .product(product1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation and observe both instances for 40 cycles after the start edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit poke, input string tag);
    logic [63:0] exp;
    logic [63:0] p0, p1;
    logic [31:0] ad0, ad1;
    int lat0, lat1, bz0, bz1, dn0, dn1, exp_lat0;
    exp = 64'(a) * 64'(b);
    exp_lat0 = ((a == 0) || (b == 0)) ? 1 : 33;
    lat0 = 0; lat1 = 0; bz0 = 0; bz1 = 0; dn0 = 0; dn1 = 0;
    p0 = '0; p1 = '0; ad0 = '1; ad1 = '1;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      junk0 = 31'($urandom); junk1 = 31'($urandom);
      if (k == 1 || (poke && k == 11)) begin
        start = 1'b0; op_a = $urandom; op_b = $urandom;
      end
      if (poke && k == 10) begin
        start = 1'b1; op_a = 32'd2; op_b = 32'd2;
      end
      if (busy0) bz0++;
      if (busy1) bz1++;
      if (done0) begin
        dn0++;
        if (lat0 == 0) begin lat0 = k; p0 = product0; ad0 = add_a0 | add_b0; end
      end
      if (done1) begin
        dn1++;
        if (lat1 == 0) begin lat1 = k; p1 = product1; ad1 = add_a1 | add_b1; end
      end
    end
    chk({tag, " lat_byp"}, 64'(lat0), 64'(exp_lat0));
    chk({tag, " lat_nobyp"}, 64'(lat1), 64'd33);
    chk({tag, " prod_byp"}, p0, exp);
    chk({tag, " prod_nobyp"}, p1, exp);
    chk({tag, " busy_byp"}, 64'(bz0), 64'(exp_lat0 - 1));
    chk({tag, " busy_nobyp"}, 64'(bz1), 64'd32);
    chk({tag, " done_cnt_byp"}, 64'(dn0), 64'd1);
    chk({tag, " done_cnt_nobyp"}, 64'(dn1), 64'd1);
    chk({tag, " addr_in_done"}, 64'(ad0 | ad1), 64'd0);
    chk({tag, " prod_hold"}, product0 ^ product1 ^ exp, exp);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          poke;
    string       name;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int first, second;
    tbl[0] = '{32'd3,          32'd5,          64'd15,                  1'b0, "3x5"};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b0, "ffxff"};
    tbl[2] = '{32'd7,          32'd9,          64'd63,                  1'b1, "7x9_poke"};
    tbl[3] = '{32'h0000_1234,  32'h0000_0010,  64'h1_2340,              1'b0, "1234x10"};
    tbl[4] = '{32'd0,          32'h0000_ABCD,  64'd0,                   1'b0, "0xabcd"};
    tbl[5] = '{32'h8000_0000,  32'd2,          64'h1_0000_0000,         1'b0, "msbx2"};
    tbl[6] = '{32'hDEAD_BEEF,  32'd0,          64'd0,                   1'b0, "x0"};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    junk0 = 31'h5A5A_5A5A; junk1 = 31'h2525_2525;
    repeat (3) @(negedge clk);
    chk("rst busy", {62'd0, busy0, busy1}, 64'd0);
    chk("rst done", {62'd0, done0, done1}, 64'd0);
    chk("rst product0", product0, 64'd0);
    chk("rst product1", product1, 64'd0);
    chk("rst adder ops", {add_a0 | add_b0, add_a1 | add_b1}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].poke, tbl[i].name);
      chk({tbl[i].name, " tbl_prod"}, product1, tbl[i].exp);
    end

    // Reset in the middle of an operation clears everything at once.
    @(negedge clk);
    start = 1'b1; op_a = 32'h1234; op_b = 32'h10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst busy", {63'd0, busy1}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy_done", {60'd0, busy0, busy1, done0, done1}, 64'd0);
    chk("midrst product", product0 | product1, 64'd0);
    chk("midrst adder ops", {add_a0 | add_b0, add_a1 | add_b1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h1234, 32'h10, 1'b0, "rerun");

    // Start held high: back-to-back issue every 34 cycles.
    first = 0; second = 0;
    @(negedge clk);
    start = 1'b1; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk);
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (done1 && done0) begin
        if (first == 0) begin
          first = k;
          chk("b2b prod1", product1, 64'd15);
          op_a = 32'd6; op_b = 32'd7;
        end else if (second == 0) begin
          second = k;
          chk("b2b prod2", product0, 64'd42);
          start = 1'b0;
        end
      end
    end
    chk("b2b first", 64'(first), 64'd33);
    chk("b2b interval", 64'(second - first), 64'd34);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 2) ra = ra | 32'h8000_0000;
      if (i == 3) rb = rb | 32'h8000_0000;
      if (i == 5) rb = 32'd0;
      do_op(ra, rb, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
